// File: rtl/reg_scoreboard_pkg.sv
// Shared widths for the dispatch scoreboard.
// Default register file and payload sizing.
package reg_scoreboard_pkg;
  localparam int DEF_NUM_REG     = 8;
  localparam int DEF_INST_ID_BIT = 8;
  localparam int DEF_IMM_BIT     = 4;
  localparam int DEF_REG_ID_BIT  = $clog2(DEF_NUM_REG);
endpackage

// File: rtl/reg_scoreboard_dec.sv
// Register index decode for the scoreboard.
// Reads of the held instruction and the busy-set mask.
module reg_scoreboard_dec #(
  parameter int NUM_REG    = 8,
  parameter int REG_ID_BIT = $clog2(NUM_REG)
) (
  input  logic                  out_full,
  input  logic [REG_ID_BIT-1:0] src0,
  input  logic [REG_ID_BIT-1:0] src1,
  input  logic [REG_ID_BIT-1:0] dst,
  input  logic                  accept,
  output logic [NUM_REG-1:0]    inflight_rd,
  output logic [NUM_REG-1:0]    set_mask
);

  always_comb begin
    inflight_rd = '0;
    set_mask    = '0;
    if (out_full) begin
      inflight_rd[src0] = 1'b1;
      inflight_rd[src1] = 1'b1;
    end
    if (accept) set_mask[dst] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Dispatch scoreboard: busy/owner tracking,
// WAW/WAR stall and a one-entry output register.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int INST_ID_BIT = DEF_INST_ID_BIT,
  parameter int NUM_REG     = DEF_NUM_REG,
  parameter int IMM_BIT     = DEF_IMM_BIT,
  parameter int REG_ID_BIT  = $clog2(NUM_REG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dec_vld,
  output logic                   dec_rdy,
  input  logic [INST_ID_BIT-1:0] dec_id,
  input  logic [REG_ID_BIT-1:0]  dec_dst_reg,
  input  logic [REG_ID_BIT-1:0]  dec_src_reg0,
  input  logic [REG_ID_BIT-1:0]  dec_src_reg1,
  input  logic [IMM_BIT-1:0]     dec_imm,
  output logic                   disp_vld,
  input  logic                   disp_rdy,
  output logic [INST_ID_BIT-1:0] disp_id,
  output logic [REG_ID_BIT-1:0]  disp_dst_reg,
  output logic [REG_ID_BIT-1:0]  disp_src_reg0,
  output logic [REG_ID_BIT-1:0]  disp_src_reg1,
  output logic [IMM_BIT-1:0]     disp_imm,
  input  logic [NUM_REG-1:0]     pending_read,
  input  logic                   wb_vld,
  input  logic [INST_ID_BIT-1:0] wb_id,
  input  logic [REG_ID_BIT-1:0]  wb_dst_reg,
  output logic [NUM_REG-1:0]     ready_reg_mask,
  output logic                   idle
);

  logic [NUM_REG-1:0]     busy_q;
  logic [INST_ID_BIT-1:0] owner_q [NUM_REG];
  logic                   out_full_q, out_full_d;
  logic [INST_ID_BIT-1:0] out_id_q, out_id_d;
  logic [REG_ID_BIT-1:0]  out_dst_q, out_dst_d;
  logic [REG_ID_BIT-1:0]  out_src0_q, out_src0_d;
  logic [REG_ID_BIT-1:0]  out_src1_q, out_src1_d;
  logic [IMM_BIT-1:0]     out_imm_q, out_imm_d;
  logic [NUM_REG-1:0]     inflight_rd, set_mask;
  logic                   hazard, slot_free, accept;

  reg_scoreboard_dec #(
    .NUM_REG    (NUM_REG),
    .REG_ID_BIT (REG_ID_BIT)
  ) u_dec (
    .out_full    (out_full_q),
    .src0        (out_src0_q),
    .src1        (out_src1_q),
    .dst         (dec_dst_reg),
    .accept      (accept),
    .inflight_rd (inflight_rd),
    .set_mask    (set_mask)
  );

  // Hazard uses registered state only; no writeback bypass.
  always_comb begin
    hazard = busy_q[dec_dst_reg]
           | pending_read[dec_dst_reg]
           | inflight_rd[dec_dst_reg];
    slot_free = !out_full_q || disp_rdy;
    dec_rdy = slot_free && !hazard;
    accept = dec_vld && dec_rdy;
  end

  always_comb begin
    out_full_d = out_full_q;
    if (accept) out_full_d = 1'b1;
    else if (out_full_q && disp_rdy) out_full_d = 1'b0;
    out_id_d   = accept ? dec_id       : out_id_q;
    out_dst_d  = accept ? dec_dst_reg  : out_dst_q;
    out_src0_d = accept ? dec_src_reg0 : out_src0_q;
    out_src1_d = accept ? dec_src_reg1 : out_src1_q;
    out_imm_d  = accept ? dec_imm      : out_imm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_full_q <= 1'b0;
    else        out_full_q <= out_full_d;
  end

  always_ff @(posedge clk) begin
    out_id_q   <= out_id_d;
    out_dst_q  <= out_dst_d;
    out_src0_q <= out_src0_d;
    out_src1_q <= out_src1_d;
    out_imm_q  <= out_imm_d;
  end

  for (genvar i = 0; i < NUM_REG; i++) begin : g_reg
    logic                   b_q, b_d;
    logic [INST_ID_BIT-1:0] o_q, o_d;
    logic                   wb_hit;

    // A new allocation overrides a same-cycle writeback.
    always_comb begin
      wb_hit = wb_vld && (wb_dst_reg == REG_ID_BIT'(i))
            && b_q && (o_q == wb_id);
      b_d = b_q;
      o_d = o_q;
      if (set_mask[i]) begin
        b_d = 1'b1;
        o_d = dec_id;
      end else if (wb_hit) begin
        b_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        b_q <= 1'b0;
        o_q <= '0;
      end else begin
        b_q <= b_d;
        o_q <= o_d;
      end
    end

    assign busy_q[i]  = b_q;
    assign owner_q[i] = o_q;
  end

  assign disp_vld       = out_full_q;
  assign disp_id        = out_id_q;
  assign disp_dst_reg   = out_dst_q;
  assign disp_src_reg0  = out_src0_q;
  assign disp_src_reg1  = out_src1_q;
  assign disp_imm       = out_imm_q;
  assign ready_reg_mask = ~busy_q;
  assign idle           = !(|busy_q) && !out_full_q;

endmodule
